// File: rtl/tlb_walk_ctrl.sv
// Shared iTLB/dTLB miss walker: round-robin grant, single PTE read, fill or fault pulse.
// States: IDLE wait for miss | REQ PTE read pending | WAIT await PTE | RESP emit pulse | DRAIN discard flushed rsp
module tlb_walk_ctrl #(
  parameter int VPN_WIDTH = 20,
  parameter int PPN_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          ptbr,
  input  logic                 flush,
  input  logic                 itlb_miss_valid,
  input  logic [31:0]          itlb_miss_vaddr,
  input  logic                 dtlb_miss_valid,
  input  logic [31:0]          dtlb_miss_vaddr,
  output logic                 itlb_fill,
  output logic                 dtlb_fill,
  output logic [52:0]          fill_info,
  output logic                 itlb_fault,
  output logic                 dtlb_fault,
  output logic                 mem_req_valid,
  output logic [31:0]          mem_req_addr,
  input  logic                 mem_req_ready,
  input  logic                 mem_rsp_valid,
  input  logic [31:0]          mem_rsp_data,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] walk_count
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, DRAIN} state_t;

  state_t                 state;
  logic                   last_d;
  logic                   side_d;
  logic [VPN_WIDTH-1:0]   vpn;
  logic                   pte_valid;
  logic                   pte_write;
  logic [PPN_WIDTH-1:0]   pte_ppn;
  logic                   grant_d;
  logic [VPN_WIDTH-1:0]   grant_vpn;
  logic                   unused_bits;

  // dTLB wins only when it is alone or the iTLB had the previous grant
  assign grant_d   = dtlb_miss_valid && (!itlb_miss_valid || !last_d);
  assign grant_vpn = grant_d ? dtlb_miss_vaddr[31:32-VPN_WIDTH] : itlb_miss_vaddr[31:32-VPN_WIDTH];
  assign busy      = (state != IDLE);
  assign unused_bits = ^{itlb_miss_vaddr[31-VPN_WIDTH:0], dtlb_miss_vaddr[31-VPN_WIDTH:0],
                         mem_rsp_data[29:PPN_WIDTH]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_d        <= 1'b1;
      side_d        <= 1'b0;
      vpn           <= '0;
      pte_valid     <= 1'b0;
      pte_write     <= 1'b0;
      pte_ppn       <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      itlb_fill     <= 1'b0;
      dtlb_fill     <= 1'b0;
      itlb_fault    <= 1'b0;
      dtlb_fault    <= 1'b0;
      fill_info     <= '0;
      walk_count    <= '0;
    end else begin
      itlb_fill  <= 1'b0;
      dtlb_fill  <= 1'b0;
      itlb_fault <= 1'b0;
      dtlb_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && (itlb_miss_valid || dtlb_miss_valid)) begin
            side_d        <= grant_d;
            last_d        <= grant_d;
            vpn           <= grant_vpn;
            mem_req_addr  <= ptbr + 32'({grant_vpn, 2'b00});
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          // a completed handshake must have its response drained even under flush
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= flush ? DRAIN : WAIT;
          end else if (flush) begin
            mem_req_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            pte_valid <= mem_rsp_data[31];
            pte_write <= mem_rsp_data[30];
            pte_ppn   <= mem_rsp_data[PPN_WIDTH-1:0];
            state     <= flush ? IDLE : RESP;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        RESP: begin
          if (pte_valid) begin
            itlb_fill <= !side_d;
            dtlb_fill <= side_d;
            fill_info <= {vpn, 12'b0, pte_ppn, 12'b0, pte_write};
          end else begin
            itlb_fault <= !side_d;
            dtlb_fault <= side_d;
            fill_info  <= '0;
          end
          if (walk_count != '1) walk_count <= walk_count + CNT_WIDTH'(1);
          state <= IDLE;
        end
        DRAIN: begin
          if (mem_rsp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_walk_ctrl.sv
// Bench for tlb_walk_ctrl: walk-level model (expected pulse queue, PTE memory) checked every cycle.
module tb_tlb_walk_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ptbr = '0;
  logic        flush = 1'b0;
  logic        itlb_miss_valid = 1'b0;
  logic [31:0] itlb_miss_vaddr = '0;
  logic        dtlb_miss_valid = 1'b0;
  logic [31:0] dtlb_miss_vaddr = '0;
  logic        itlb_fill, dtlb_fill, itlb_fault, dtlb_fault;
  logic [52:0] fill_info;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        busy;
  logic [15:0] walk_count;

  tlb_walk_ctrl dut (
    .clock(clock), .reset(reset), .ptbr(ptbr), .flush(flush),
    .itlb_miss_valid(itlb_miss_valid), .itlb_miss_vaddr(itlb_miss_vaddr),
    .dtlb_miss_valid(dtlb_miss_valid), .dtlb_miss_vaddr(dtlb_miss_vaddr),
    .itlb_fill(itlb_fill), .dtlb_fill(dtlb_fill), .fill_info(fill_info),
    .itlb_fault(itlb_fault), .dtlb_fault(dtlb_fault),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy), .walk_count(walk_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          side;
    bit          fault;
    logic [31:0] addr;
    logic [52:0] info;
  } walk_t;

  walk_t       exp_q[$];
  logic [31:0] pte_mem [logic [31:0]];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          model_last_d = 1'b1;
  logic [15:0] model_count = '0;
  int          rsp_delay = 1;
  bit          ready_rand = 1'b0;
  bit          ready_low = 1'b0;
  int          hs_count = 0;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = '0;
  int          r_first_at;
  logic [3:0]  r_first_flags;
  logic [52:0] r_first_info;
  logic [31:0] r_first_addr;
  int          hold_n;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, expv);
    end
  endtask

  function automatic walk_t make_walk(input bit side, input logic [31:0] pb, input logic [31:0] va,
                                      input logic [31:0] pte);
    walk_t       w;
    logic [31:0] page;
    page    = va >> 12;
    w.side  = side;
    w.addr  = pb + page * 4;
    w.fault = !pte[31];
    w.info  = pte[31] ? ((53'(page) << 33) | (53'(pte & 32'hFF) << 13) | 53'(pte[30])) : 53'd0;
    return w;
  endfunction

  // Memory responder: accepts at the clock edge, answers rsp_delay edges later.
  always @(clock) begin
    if (clock) begin
      if (!reset && mem_req_valid && mem_req_ready) begin
        hs_count++;
        rsp_cnt  = rsp_delay;
        rsp_addr = mem_req_addr;
      end
    end else begin
      mem_req_ready = ready_low ? 1'b0 : (ready_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      if (reset) begin
        rsp_cnt       = 0;
        mem_rsp_valid = 1'b0;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
        mem_rsp_valid = (rsp_cnt == 0);
        mem_rsp_data  = pte_mem.exists(rsp_addr) ? pte_mem[rsp_addr] : 32'h0;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
      end
    end
  end

  walk_t      cmp_w;
  logic [3:0] flags;
  always @(negedge clock) begin
    if (reset) begin
      model_count = '0;
      exp_q.delete();
    end else begin
      flags = {itlb_fill, dtlb_fill, itlb_fault, dtlb_fault};
      chk("pulse_onehot", 64'($countones(flags) <= 1), 1);
      if (flags != 4'b0000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", flags, 0);
        end else begin
          cmp_w = exp_q.pop_front();
          chk("pulse_kind", flags, cmp_w.fault ? (cmp_w.side ? 4'b0001 : 4'b0010)
                                               : (cmp_w.side ? 4'b0100 : 4'b1000));
          chk("fill_info", fill_info, cmp_w.info);
          if (model_count != 16'hFFFF) model_count++;
        end
      end
      chk("walk_count", walk_count, model_count);
      if (mem_req_valid) begin
        if (exp_q.size() == 0) chk("stray_req", mem_req_valid, 0);
        else                   chk("req_addr", mem_req_addr, exp_q[0].addr);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    itlb_miss_valid = 1'b0;
    dtlb_miss_valid = 1'b0;
    flush = 1'b0;
    model_last_d = 1'b1;
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_fill_info", fill_info, 0);
    chk("rst_walk_count", walk_count, 0);
    chk("rst_pulses", {itlb_fill, dtlb_fill, itlb_fault, dtlb_fault}, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic start_single(input bit side, input logic [31:0] pb, input logic [31:0] va,
                              input logic [31:0] pte);
    walk_t w;
    w = make_walk(side, pb, va, pte);
    pte_mem[w.addr] = pte;
    exp_q.push_back(w);
    model_last_d = side;
    ptbr = pb;
    if (side) begin dtlb_miss_vaddr = va; dtlb_miss_valid = 1'b1; end
    else      begin itlb_miss_vaddr = va; itlb_miss_valid = 1'b1; end
  endtask

  task automatic walk_round(input bit ui, input bit ud, input logic [31:0] pb,
                            input logic [31:0] vi, input logic [31:0] vd,
                            input logic [31:0] pi, input logic [31:0] pd, input int rdel);
    walk_t wi, wd;
    bit    addr_seen;
    wi = make_walk(1'b0, pb, vi, pi);
    wd = make_walk(1'b1, pb, vd, pd);
    if (ui && ud && wi.addr == wd.addr) wd = make_walk(1'b1, pb, vd, pi);
    if (ud) pte_mem[wd.addr] = (ui && wi.addr == wd.addr) ? pi : pd;
    if (ui) pte_mem[wi.addr] = pi;
    // simultaneous pair: the side not granted last goes first, so last grant is unchanged
    if (ui && ud) begin
      if (model_last_d) begin exp_q.push_back(wi); exp_q.push_back(wd); end
      else              begin exp_q.push_back(wd); exp_q.push_back(wi); end
    end else if (ui) begin
      exp_q.push_back(wi); model_last_d = 1'b0;
    end else begin
      exp_q.push_back(wd); model_last_d = 1'b1;
    end
    ptbr = pb;
    rsp_delay = rdel;
    itlb_miss_vaddr = vi;
    dtlb_miss_vaddr = vd;
    itlb_miss_valid = ui;
    dtlb_miss_valid = ud;
    r_first_at = -1;
    r_first_flags = '0;
    r_first_info = '0;
    r_first_addr = '0;
    hold_n = 0;
    addr_seen = 1'b0;
    for (int c = 0; c < 300 && exp_q.size() > 0; c++) begin
      @(negedge clock);
      if (mem_req_valid && !addr_seen) begin
        addr_seen = 1'b1;
        r_first_addr = mem_req_addr;
      end
      if (ready_low && addr_seen) begin
        hold_n++;
        chk("hold_valid", mem_req_valid, 1);
        chk("hold_addr", mem_req_addr, r_first_addr);
        if (hold_n == 5) ready_low = 1'b0;
      end
      if (r_first_at < 0 && (itlb_fill | dtlb_fill | itlb_fault | dtlb_fault)) begin
        r_first_at = c;
        r_first_flags = {itlb_fill, dtlb_fill, itlb_fault, dtlb_fault};
        r_first_info = fill_info;
      end
      if (itlb_fill || itlb_fault) itlb_miss_valid = 1'b0;
      if (dtlb_fill || dtlb_fault) dtlb_miss_valid = 1'b0;
    end
    @(negedge clock);
    chk("walks_done", exp_q.size(), 0);
    exp_q.delete();
    itlb_miss_valid = 1'b0;
    dtlb_miss_valid = 1'b0;
    ready_low = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_req_valid", mem_req_valid, 0);
  endtask

  initial begin
    int          hs0;
    int          c;
    logic [15:0] cnt0;
    logic [1:0]  sel;

    do_reset();

    // Single iTLB walk with hand-computed address, info and latency
    walk_round(1'b1, 1'b0, 32'h0001_0000, 32'h0000_3ABC, 32'h0, 32'hC000_0055, 32'h0, 2);
    chk("t1_latency", r_first_at, 4);
    chk("t1_addr", r_first_addr, 32'h0001_000C);
    chk("t1_info", r_first_info, 53'h0_0006_000A_A001);
    chk("t1_flags", r_first_flags, 4'b1000);
    chk("t1_count", walk_count, 1);

    // Simultaneous pairs after reset: iTLB first both times
    do_reset();
    walk_round(1'b1, 1'b1, 32'h0004_0000, 32'h0000_5000, 32'h0000_7000, 32'h8000_0011, 32'hC000_0022, 1);
    chk("t2_pair1_first", r_first_flags, 4'b1000);
    walk_round(1'b1, 1'b1, 32'h0004_0000, 32'h0001_1000, 32'h0002_2000, 32'h8000_0033, 32'h8000_0044, 1);
    chk("t2_pair2_first", r_first_flags, 4'b1000);
    chk("t2_count", walk_count, 4);

    // dTLB fault
    walk_round(1'b0, 1'b1, 32'h0008_0000, 32'h0, 32'h0ABC_D123, 32'h0, 32'h0000_0012, 1);
    chk("t3_flags", r_first_flags, 4'b0001);
    chk("t3_info", r_first_info, 0);

    // Memory stalls the request for 5 cycles
    ready_low = 1'b1;
    @(negedge clock);
    hs0 = hs_count;
    walk_round(1'b1, 1'b0, 32'h0010_0000, 32'h0040_2000, 32'h0, 32'h8000_0077, 32'h0, 1);
    chk("t4_hold_cycles", hold_n, 5);
    chk("t4_one_request", hs_count - hs0, 1);

    // Flush in WAIT: response 3 cycles later is drained
    rsp_delay = 4;
    hs0 = hs_count;
    cnt0 = model_count;
    start_single(1'b0, 32'h0002_0000, 32'h1234_5000, 32'h8000_00AA);
    c = 0;
    while (hs_count == hs0 && c < 50) begin @(negedge clock); c++; end
    chk("t5_accept", hs_count - hs0, 1);
    flush = 1'b1;
    itlb_miss_valid = 1'b0;
    @(negedge clock);
    flush = 1'b0;
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    chk("t5_drain_busy", busy, 1);
    @(negedge clock);
    chk("t5_drain_done", busy, 0);
    chk("t5_count", walk_count, cnt0);
    walk_round(1'b0, 1'b1, 32'h0002_0000, 32'h0, 32'h0000_9000, 32'h0, 32'h8000_0099, 1);
    chk("t5_next_flags", r_first_flags, 4'b0100);

    // Flush in REQ withdraws the request
    ready_low = 1'b1;
    @(negedge clock);
    hs0 = hs_count;
    start_single(1'b1, 32'h0003_0000, 32'h0000_8000, 32'h8000_0001);
    c = 0;
    while (!mem_req_valid && c < 20) begin @(negedge clock); c++; end
    chk("t6_req_seen", mem_req_valid, 1);
    flush = 1'b1;
    dtlb_miss_valid = 1'b0;
    @(negedge clock);
    flush = 1'b0;
    ready_low = 1'b0;
    chk("t6_withdrawn", mem_req_valid, 0);
    chk("t6_idle", busy, 0);
    exp_q.delete();
    @(negedge clock);
    chk("t6_no_handshake", hs_count - hs0, 0);

    // Randomized rounds with random ready and response latency
    ready_rand = 1'b1;
    for (int r = 0; r < 40; r++) begin
      sel = 2'($urandom_range(1, 3));
      walk_round(sel[0], sel[1], $urandom, $urandom, $urandom,
                 {1'($urandom_range(0, 1)), 31'($urandom)},
                 {1'($urandom_range(0, 1)), 31'($urandom)},
                 $urandom_range(1, 4));
    end
    ready_rand = 1'b0;

    // Asynchronous reset in the middle of WAIT
    rsp_delay = 6;
    hs0 = hs_count;
    start_single(1'b0, 32'h0005_0000, 32'h0000_4000, 32'h8000_0042);
    c = 0;
    while (hs_count == hs0 && c < 50) begin @(negedge clock); c++; end
    @(negedge clock);
    #2;
    reset = 1'b1;
    itlb_miss_valid = 1'b0;
    #1;
    chk("t8_busy", busy, 0);
    chk("t8_walk_count", walk_count, 0);
    chk("t8_req_valid", mem_req_valid, 0);
    chk("t8_req_addr", mem_req_addr, 0);
    chk("t8_fill_info", fill_info, 0);
    chk("t8_pulses", {itlb_fill, dtlb_fill, itlb_fault, dtlb_fault}, 0);
    @(negedge clock);
    model_last_d = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    walk_round(1'b1, 1'b1, 32'h0006_0000, 32'h0000_1000, 32'h0000_2000, 32'h8000_0005, 32'h0000_0000, 1);
    chk("t8_recover_first", r_first_flags, 4'b1000);
    chk("t8_recover_count", walk_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/tlb_walk_ctrl.md
Name: tlb_walk_ctrl

Overview:
- Hardware TLB-miss controller shared by the instruction-side and data-side tlb_cache instances.
- Arbitrates round-robin between the two miss requesters and reads one 32-bit PTE from a single-level page table in memory.
- Either drives the requester's new_tlb_entry/new_tlb_info fill pulse or reports a page fault.
- Sits between the TLBs and the memory arbiter port; only one walk is in flight at a time.

Parameters:
VPN_WIDTH, 20, virtual page number width (vaddr[31:12])
PPN_WIDTH, 8, physical page number width (PTE[7:0])
CNT_WIDTH, 16, width of the saturating walk counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ptbr  in  32  page table base byte address, sampled at grant
flush  in  1  abort any walk in progress; no fill/fault for the aborted walk
itlb_miss_valid  in  1  iTLB miss pending; held high until itlb_fill or itlb_fault
itlb_miss_vaddr  in  32  iTLB miss virtual address
dtlb_miss_valid  in  1  dTLB miss pending; same rule
dtlb_miss_vaddr  in  32  dTLB miss virtual address
itlb_fill  out  1  one-cycle pulse; connects to iTLB new_tlb_entry
dtlb_fill  out  1  one-cycle pulse; connects to dTLB new_tlb_entry
fill_info  out  53  shared new_tlb_info: [52:33]=VPN, [20:13]=PPN, [0]=write permission, all other bits 0
itlb_fault  out  1  one-cycle pulse; iTLB PTE invalid
dtlb_fault  out  1  one-cycle pulse; dTLB PTE invalid
mem_req_valid  out  1  PTE read request
mem_req_addr  out  32  PTE byte address
mem_req_ready  in  1  memory accepts request when valid&ready
mem_rsp_valid  in  1  PTE data valid (single beat)
mem_rsp_data  in  32  PTE: [31]=valid, [30]=write, [7:0]=PPN
busy  out  1  high in every state except IDLE
walk_count  out  CNT_WIDTH  completed walks (fills + faults), saturating

Behaviour:
- Reset (async): state=IDLE, last_grant=dTLB (so iTLB wins the first tie), all pulses 0, mem_req_valid=0, mem_req_addr=0, fill_info=0, walk_count=0.
- States: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE:
  - If flush is high, stay in IDLE.
  - Otherwise, if any miss_valid is high, grant a requester. Single requester: grant it. Both: grant the one not in last_grant.
  - At grant, register requester id, VPN=vaddr[31:12], and mem_req_addr = ptbr + {VPN,2'b00} (mod 2^32); update last_grant; go to REQ.
  - mem_req_valid rises the cycle after the grant edge.
- REQ:
  - mem_req_valid=1; address stable until accepted.
  - On valid&ready, go to WAIT; mem_req_valid drops the next cycle.
  - flush in REQ goes to IDLE and the request is withdrawn (no handshake has completed).
  - If flush and ready occur in the same cycle, the handshake counts: go to DRAIN.
- WAIT:
  - On mem_rsp_valid, register the PTE and go to RESP.
  - flush in WAIT goes to DRAIN. flush coincident with mem_rsp_valid goes to IDLE with no pulse.
- RESP (exactly one cycle):
  - PTE[31]=1: assert the granted side's fill; fill_info={VPN,12'b0,PPN,12'b0,PTE[30]}.
  - PTE[31]=0: assert the granted side's fault; fill_info=0.
  - Increment walk_count, saturating at all-ones. Go to IDLE.
  - A flush arriving in RESP does not suppress the pulse.
- DRAIN: wait for mem_rsp_valid, discard it, go to IDLE. No pulse and no count.
- Latency from IDLE grant with ready=1 and a response one cycle after acceptance: fill pulse 4 cycles after the grant edge.
- mem_rsp_valid outside WAIT/DRAIN is ignored.
- A requester that drops miss_valid mid-walk still receives its pulse. The requester must tolerate this.
- New grants are only made in IDLE, so the earliest re-grant is the cycle after RESP.
- Only one fill or fault output is high in any cycle.

Test Plan:
- ptbr=0x0001_0000, iTLB miss vaddr=0x0000_3ABC, PTE=0xC000_0055 -> mem_req_addr=0x0001_000C; itlb_fill pulse with fill_info[52:33]=0x00003, [20:13]=0x55, [0]=1; walk_count=1.
- Both misses in the same cycle after reset, both PTEs valid -> iTLB served first, then dTLB; next simultaneous pair -> iTLB again (alternation holds).
- dTLB miss, PTE=0x0000_0012 -> dtlb_fault single pulse, dtlb_fill never high, fill_info=0.
- mem_req_ready held low 5 cycles -> mem_req_valid and mem_req_addr stable for all 5 cycles; exactly one request is issued.
- flush in WAIT, response arrives 3 cycles later -> DRAIN absorbs it; no fill or fault; walk_count unchanged; next miss is served normally.
- reset asserted mid-WAIT -> outputs go to reset values immediately; busy=0; walk_count=0.
